microwave_timer: RTL and testbench
==================================

MICROWAVE_TIMER -- requirements
Module: microwave_timer

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Port `clk`: input, 1 bit, system clock; all state changes on its rising edge.
REQ-003 Port `resetn`: input, 1 bit, asynchronous active-low reset.
REQ-004 Port `tick`: input, 1 bit, single-cycle 1 Hz enable pulse from the clock divider.
REQ-005 Port `key_valid`: input, 1 bit, single-cycle strobe qualifying `key_digit`.
REQ-006 Port `key_digit`: input, 4 bits, BCD keypad digit.
REQ-007 Port `clearn`: input, 1 bit, synchronous clear; active low.
REQ-008 Port `count_en`: input, 1 bit, magnetron-on indication from the magnetron SR latch; 1 = heating.
REQ-009 Port `min_tens`, `min_ones`, `sec_tens`, `sec_ones`: output, 4 bits each, BCD display digits of MM:SS.
REQ-010 Port `timer_done`: output, 1 bit; 1 when the count is 00:00, i.e. the timer is not in operation.
REQ-011 Port `done_pulse`: output, 1 bit, single-cycle pulse when a running countdown reaches 00:00 (beeper).
REQ-012 Port `state`: output, 2 bits, current FSM state, for display and debug.

Function
REQ-013 The FSM SHALL have exactly four states: EMPTY (count zero), SET (count nonzero, idle), RUN (counting), PAUSE (count nonzero, halted).
REQ-014 `clearn`=0 SHALL force all digits to 0 and the state to EMPTY on the next edge, from any state, overriding every other input.
REQ-015 In EMPTY or SET, `key_valid`=1 with `key_digit`<=9 SHALL shift the digits left by one place: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
REQ-016 A digit shifted out of min_tens SHALL be discarded.
REQ-017 `key_valid` with `key_digit`>9 SHALL be ignored.
REQ-018 `key_valid` SHALL be ignored in RUN and PAUSE.
REQ-019 After a key shift, the state SHALL be SET if the resulting count is nonzero, otherwise EMPTY.
REQ-020 Transitions: SET, or PAUSE with `count_en`=1, SHALL go to RUN. RUN with `count_en`=0 SHALL go to PAUSE. EMPTY SHALL ignore `count_en`.
REQ-021 A `tick` on the same edge as entry into RUN SHALL NOT decrement.
REQ-022 In RUN, each `tick` SHALL decrement the count by one second using BCD borrow:
- sec_ones 0 -> 9 with borrow;
- sec_tens 0 -> 5 with borrow;
- min_ones 0 -> 9 with borrow;
- min_tens decrements on borrow.
REQ-023 Keypad values of sec_tens above 5 (e.g. 99 s) SHALL be accepted and counted down normally.
REQ-024 When a decrement in RUN produces 00:00, the state SHALL go to EMPTY and `done_pulse` SHALL be 1 for exactly that following cycle.
REQ-025 `tick` SHALL have no effect in EMPTY, SET and PAUSE.
REQ-026 `timer_done` SHALL be a registered-state decode, equal to 1 exactly when the state is EMPTY.
REQ-027 `timer_done` SHALL be glitch-free and SHALL NOT depend combinationally on any input.
REQ-028 Priority SHALL be: `clearn` > tick decrement/`count_en` > `key_valid`.

Reset
REQ-029 `resetn`=0 SHALL immediately set:
- all digits = 0;
- state = EMPTY;
- `timer_done` = 1;
- `done_pulse` = 0.
REQ-030 Reset asserted mid-countdown SHALL abort the countdown without producing `done_pulse`.
REQ-031 Operation SHALL resume on the first rising clock edge after `resetn` deasserts.

Structure
REQ-032 A shared package SHALL hold:
- the state encoding (EMPTY=0, SET=1, RUN=2, PAUSE=3);
- the BCD width (4);
- the digit maxima (9, 5).
REQ-033 One sub-module `bcd_down_digit` SHALL be used, four times. Parameter: wrap value. Inputs: load/shift value, decrement enable. Outputs: digit, borrow-out.

Verification
REQ-034 Reset, then keys 1,3,0 -> digits 01:30, state SET, `timer_done`=0.
REQ-035 From 01:30, set `count_en`=1, then 3 ticks -> 01:27; one more tick from 01:00 -> 00:59.
REQ-036 From 00:02 in RUN, 2 ticks -> 00:00, state EMPTY, `timer_done`=1, `done_pulse` high for exactly 1 cycle.
REQ-037 From RUN at 00:45, drop `count_en`, then 5 ticks -> still 00:45 in PAUSE; key 7 ignored; raise `count_en` -> RUN.
REQ-038 From RUN at 05:00, assert `clearn` on the same edge as `tick` and `key_valid` -> 00:00, EMPTY, no `done_pulse`.
REQ-039 Keys 9,9 then run, 1 tick -> 00:98; assert `resetn` mid-run -> all zero, `timer_done`=1 asynchronously.

Source files
------------

// File: rtl/microwave_timer_pkg.sv
// ----------------------------------------------------------------------------
// microwave_timer_pkg
// Definitions shared by the microwave timer:
//   - state_e   : FSM state encoding (EMPTY=0, SET=1, RUN=2, PAUSE=3)
//   - BCD_W     : width of one BCD display digit
//   - DIGIT_MAX : wrap value of a decimal digit (9)
//   - TENS_MAX  : wrap value of the seconds-tens digit (5)
//   - is_bcd()  : true when a keypad code is a legal decimal digit
// ----------------------------------------------------------------------------
package microwave_timer_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
    localparam logic [BCD_W-1:0] TENS_MAX  = 4'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SET   = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/microwave_timer_bcd_down_digit.sv
// ----------------------------------------------------------------------------
// bcd_down_digit
// One BCD digit of the MM:SS display. It can be cleared, loaded (keypad
// shift) or decremented; a decrement from 0 wraps to WRAP and raises borrow.
//
// Parameters:
//   WRAP        value loaded when decrementing from 0
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset (digit -> 0)
//   i_clear     synchronous clear, highest priority
//   i_load      load i_load_val (keypad shift)
//   i_load_val  value to load
//   i_dec       decrement enable (tick or borrow from the lower digit)
//   o_digit     current digit value
//   o_borrow    combinational borrow-out: i_dec while the digit is 0
// ----------------------------------------------------------------------------
module bcd_down_digit
    import microwave_timer_pkg::*;
#(
    parameter logic [BCD_W-1:0] WRAP = DIGIT_MAX
)
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_borrow
);

    localparam logic [BCD_W-1:0] ONE = {{(BCD_W-1){1'b0}}, 1'b1};

    logic [BCD_W-1:0] r_digit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_digit <= '0;
        end else if (i_clear) begin
            r_digit <= '0;
        end else if (i_dec) begin
            r_digit <= (r_digit == '0) ? WRAP : (r_digit - ONE);
        end else if (i_load) begin
            r_digit <= i_load_val;
        end
    end

    assign o_digit  = r_digit;
    assign o_borrow = i_dec && (r_digit == '0);

endmodule

// File: rtl/microwave_timer.sv
// ----------------------------------------------------------------------------
// microwave_timer
// Keypad-entered MM:SS countdown timer for a microwave oven.
//
// Ports:
//   clk         system clock (rising edge)
//   resetn      asynchronous active-low reset
//   tick        1 Hz single-cycle enable from the clock divider
//   key_valid   strobe qualifying key_digit
//   key_digit   BCD keypad digit; codes above 9 are ignored
//   clearn      synchronous clear, active low, overrides everything
//   count_en    magnetron-on indication; 1 = heating
//   min_tens, min_ones, sec_tens, sec_ones : BCD display digits
//   timer_done  1 while the timer is idle at 00:00 (state EMPTY), registered
//   done_pulse  one-cycle pulse when a running countdown reaches 00:00
//   state       current FSM state (EMPTY/SET/RUN/PAUSE)
// ----------------------------------------------------------------------------
module microwave_timer
    import microwave_timer_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_digit,
    input  logic             clearn,
    input  logic             count_en,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             timer_done,
    output logic             done_pulse,
    output logic [1:0]       state
);

    state_e r_state;
    logic   r_timer_done;
    logic   r_done_pulse;

    // Digit 0 is sec_ones, digit 3 is min_tens.
    logic [BCD_W-1:0] w_digit    [4];
    logic [BCD_W-1:0] w_load_val [4];
    logic [4:0]       w_dec_chain;
    logic             w_tick_dec;
    logic             w_shift;
    logic             w_shift_zero;
    logic             w_start;
    logic             w_is_one;
    logic             w_underflow;
    logic             w_clear;

    // Count-enable outranks the keypad, so a key arriving while SET is
    // being started is dropped.
    assign w_start    = (r_state == ST_SET) && count_en;
    assign w_shift    = key_valid && is_bcd(key_digit) &&
                        ((r_state == ST_EMPTY) || ((r_state == ST_SET) && !count_en));
    assign w_tick_dec = clearn && (r_state == ST_RUN) && count_en && tick;

    // The count after a shift is zero when the three surviving digits and
    // the new key are all zero (min_tens is shifted out).
    assign w_shift_zero = (w_digit[2] == '0) && (w_digit[1] == '0) &&
                          (w_digit[0] == '0) && (key_digit == '0);

    // A decrement reaches 00:00 exactly when the count is 00:01.
    assign w_is_one = (w_digit[3] == '0) && (w_digit[2] == '0) &&
                      (w_digit[1] == '0) && (w_digit[0] == 4'd1);

    // A borrow out of min_tens would mean the count wrapped below 00:00;
    // RUN always holds a nonzero count so it is not expected, but if it
    // happens the count is forced back to zero and the run ends.
    assign w_underflow = w_dec_chain[4];
    assign w_clear     = !clearn || w_underflow;

    assign w_dec_chain[0] = w_tick_dec;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            if (gi == 0) begin : g_first
                assign w_load_val[gi] = key_digit;
            end else begin : g_rest
                assign w_load_val[gi] = w_digit[gi-1];
            end

            bcd_down_digit #(
                .WRAP ((gi == 1) ? TENS_MAX : DIGIT_MAX)
            ) u_digit (
                .clk        (clk),
                .resetn     (resetn),
                .i_clear    (w_clear),
                .i_load     (w_shift),
                .i_load_val (w_load_val[gi]),
                .i_dec      (w_dec_chain[gi]),
                .o_digit    (w_digit[gi]),
                .o_borrow   (w_dec_chain[gi+1])
            );
        end
    endgenerate

    // timer_done is kept in its own flop, updated together with the state,
    // so it never decodes combinationally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_EMPTY;
            r_timer_done <= 1'b1;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (!clearn) begin
                r_state      <= ST_EMPTY;
                r_timer_done <= 1'b1;
            end else begin
                case (r_state)
                    ST_EMPTY, ST_SET: begin
                        if (w_start) begin
                            r_state      <= ST_RUN;
                            r_timer_done <= 1'b0;
                        end else if (w_shift) begin
                            if (w_shift_zero) begin
                                r_state      <= ST_EMPTY;
                                r_timer_done <= 1'b1;
                            end else begin
                                r_state      <= ST_SET;
                                r_timer_done <= 1'b0;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (!count_en) begin
                            r_state      <= ST_PAUSE;
                            r_timer_done <= 1'b0;
                        end else if (w_tick_dec && (w_is_one || w_underflow)) begin
                            r_state      <= ST_EMPTY;
                            r_timer_done <= 1'b1;
                            r_done_pulse <= 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (count_en) begin
                            r_state      <= ST_RUN;
                            r_timer_done <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= ST_EMPTY;
                        r_timer_done <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign min_tens   = w_digit[3];
    assign min_ones   = w_digit[2];
    assign sec_tens   = w_digit[1];
    assign sec_ones   = w_digit[0];
    assign timer_done = r_timer_done;
    assign done_pulse = r_done_pulse;
    assign state      = r_state;

endmodule

// File: tb/tb_microwave_timer.sv
// ----------------------------------------------------------------------------
// tb_microwave_timer
// Directed vector table, random stimulus against a seconds-level reference
// model, and hand-written reset sequences for the microwave timer.
// ----------------------------------------------------------------------------
module tb_microwave_timer;

    logic       clk;
    logic       resetn;
    logic       tick;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       clearn;
    logic       count_en;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       timer_done;
    logic       done_pulse;
    logic [1:0] state;

    microwave_timer dut (
        .clk        (clk),
        .resetn     (resetn),
        .tick       (tick),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .clearn     (clearn),
        .count_en   (count_en),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .timer_done (timer_done),
        .done_pulse (done_pulse),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_EMPTY = 0;
    localparam int S_SET   = 1;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 3;

    typedef struct {
        logic        clr_n;
        logic        kv;
        logic [3:0]  kd;
        logic        ce;
        logic        tk;
        logic [15:0] exp_bcd;
        logic [1:0]  exp_st;
        logic        exp_dp;
    } vec_t;

    vec_t vecs[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the count is the four-digit decimal number MMSS.
    int m_n;
    int m_st;
    bit m_dp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic row(input logic c, input logic kv, input logic [3:0] kd, input logic ce,
                       input logic tk, input logic [15:0] e_bcd, input int e_st, input logic e_dp);
        vec_t v;
        v.clr_n = c; v.kv = kv; v.kd = kd; v.ce = ce; v.tk = tk;
        v.exp_bcd = e_bcd; v.exp_st = 2'(e_st); v.exp_dp = e_dp;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic c, input logic kv, input logic [3:0] kd,
                         input logic ce, input logic tk);
        clearn = c; key_valid = kv; key_digit = kd; count_en = ce; tick = tk;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [19:0] dut_vec();
        return {min_tens, min_ones, sec_tens, sec_ones, state, timer_done, done_pulse};
    endfunction

    // One clock edge of the reference model, from the specification's rules.
    task automatic model_step();
        int ss;
        int mm;
        m_dp = 1'b0;
        if (!clearn) begin
            m_n  = 0;
            m_st = S_EMPTY;
        end else begin
            case (m_st)
                S_EMPTY, S_SET: begin
                    if (m_st == S_SET && count_en) begin
                        m_st = S_RUN;
                    end else if (key_valid && key_digit <= 4'd9) begin
                        m_n  = (m_n * 10 + int'(key_digit)) % 10000;
                        m_st = (m_n != 0) ? S_SET : S_EMPTY;
                    end
                end
                S_RUN: begin
                    if (!count_en) begin
                        m_st = S_PAUSE;
                    end else if (tick) begin
                        ss = m_n % 100;
                        mm = m_n / 100;
                        if (ss > 0) m_n = m_n - 1;
                        else        m_n = (mm - 1) * 100 + 59;
                        if (m_n == 0) begin
                            m_st = S_EMPTY;
                            m_dp = 1'b1;
                        end
                    end
                end
                default: begin
                    if (count_en) m_st = S_RUN;
                end
            endcase
        end
    endtask

    initial begin
        resetn = 1'b0; clearn = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
        count_en = 1'b0; tick = 1'b0;

        // ---------------- reset state ----------------
        #23;
        check("reset_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("reset_state", state, S_EMPTY);
        check("reset_timer_done", timer_done, 1'b1);
        check("reset_done_pulse", done_pulse, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- directed vector table ----------------
        //   clr kv kd ce tk  expected   state    pulse
        row(1, 1, 1, 0, 0, 16'h0001, S_SET,   0);
        row(1, 1, 3, 0, 0, 16'h0013, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h0130, S_SET,   0);
        row(1, 0, 0, 1, 0, 16'h0130, S_RUN,   0);
        row(1, 0, 0, 1, 1, 16'h0129, S_RUN,   0);
        row(1, 0, 0, 1, 1, 16'h0128, S_RUN,   0);
        row(1, 0, 0, 1, 1, 16'h0127, S_RUN,   0);
        row(0, 0, 0, 1, 0, 16'h0000, S_EMPTY, 0);
        row(1, 1, 1, 0, 0, 16'h0001, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h0010, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h0100, S_SET,   0);
        row(1, 0, 0, 1, 0, 16'h0100, S_RUN,   0);
        row(1, 0, 0, 1, 1, 16'h0059, S_RUN,   0);
        row(1, 0, 0, 1, 1, 16'h0058, S_RUN,   0);
        row(0, 0, 0, 0, 0, 16'h0000, S_EMPTY, 0);
        row(1, 1, 2, 0, 0, 16'h0002, S_SET,   0);
        row(1, 0, 0, 1, 0, 16'h0002, S_RUN,   0);
        row(1, 0, 0, 1, 1, 16'h0001, S_RUN,   0);
        row(1, 0, 0, 1, 1, 16'h0000, S_EMPTY, 1);
        row(1, 0, 0, 1, 1, 16'h0000, S_EMPTY, 0);
        row(1, 1, 4, 0, 0, 16'h0004, S_SET,   0);
        row(1, 1, 5, 0, 0, 16'h0045, S_SET,   0);
        row(1, 0, 0, 1, 0, 16'h0045, S_RUN,   0);
        row(1, 0, 0, 0, 0, 16'h0045, S_PAUSE, 0);
        row(1, 0, 0, 0, 1, 16'h0045, S_PAUSE, 0);
        row(1, 0, 0, 0, 1, 16'h0045, S_PAUSE, 0);
        row(1, 0, 0, 0, 0, 16'h0045, S_PAUSE, 0);
        row(1, 0, 0, 0, 1, 16'h0045, S_PAUSE, 0);
        row(1, 0, 0, 0, 1, 16'h0045, S_PAUSE, 0);
        row(1, 0, 0, 0, 1, 16'h0045, S_PAUSE, 0);
        row(1, 1, 7, 0, 0, 16'h0045, S_PAUSE, 0);
        row(1, 0, 0, 1, 0, 16'h0045, S_RUN,   0);
        row(1, 0, 0, 1, 1, 16'h0044, S_RUN,   0);
        row(0, 0, 0, 0, 0, 16'h0000, S_EMPTY, 0);
        row(1, 1, 5, 0, 0, 16'h0005, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h0050, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h0500, S_SET,   0);
        row(1, 0, 0, 1, 0, 16'h0500, S_RUN,   0);
        row(0, 1, 3, 1, 1, 16'h0000, S_EMPTY, 0);
        row(1, 0, 0, 0, 0, 16'h0000, S_EMPTY, 0);
        row(1, 1, 12, 0, 0, 16'h0000, S_EMPTY, 0);
        row(1, 1, 9, 0, 0, 16'h0009, S_SET,   0);
        row(1, 1, 15, 0, 0, 16'h0009, S_SET,  0);
        row(0, 0, 0, 0, 0, 16'h0000, S_EMPTY, 0);
        row(1, 1, 1, 0, 0, 16'h0001, S_SET,   0);
        row(1, 1, 2, 0, 0, 16'h0012, S_SET,   0);
        row(1, 1, 3, 0, 0, 16'h0123, S_SET,   0);
        row(1, 1, 4, 0, 0, 16'h1234, S_SET,   0);
        row(1, 1, 5, 0, 0, 16'h2345, S_SET,   0);
        row(0, 0, 0, 0, 0, 16'h0000, S_EMPTY, 0);
        row(1, 1, 1, 0, 0, 16'h0001, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h0010, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h0100, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h1000, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h0000, S_EMPTY, 0);
        row(1, 1, 3, 0, 0, 16'h0003, S_SET,   0);
        row(1, 0, 0, 1, 1, 16'h0003, S_RUN,   0);
        row(1, 0, 0, 1, 1, 16'h0002, S_RUN,   0);
        row(1, 1, 8, 1, 0, 16'h0002, S_RUN,   0);
        row(1, 0, 0, 0, 1, 16'h0002, S_PAUSE, 0);
        row(0, 0, 0, 0, 0, 16'h0000, S_EMPTY, 0);
        row(1, 1, 4, 0, 0, 16'h0004, S_SET,   0);
        row(1, 1, 6, 1, 0, 16'h0004, S_RUN,   0);
        row(0, 0, 0, 0, 0, 16'h0000, S_EMPTY, 0);
        row(1, 1, 1, 0, 0, 16'h0001, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h0010, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h0100, S_SET,   0);
        row(1, 1, 0, 0, 0, 16'h1000, S_SET,   0);
        row(1, 0, 0, 1, 0, 16'h1000, S_RUN,   0);
        row(1, 0, 0, 1, 1, 16'h0959, S_RUN,   0);

        foreach (vecs[i]) begin
            apply(vecs[i].clr_n, vecs[i].kv, vecs[i].kd, vecs[i].ce, vecs[i].tk);
            $display("vec%0d clr=%0b kv=%0b kd=%0d ce=%0b tk=%0b -> %h%h:%h%h st=%0d done=%0b pulse=%0b",
                     i, vecs[i].clr_n, vecs[i].kv, vecs[i].kd, vecs[i].ce, vecs[i].tk,
                     min_tens, min_ones, sec_tens, sec_ones, state, timer_done, done_pulse);
            check($sformatf("vec%0d", i), dut_vec(),
                  {vecs[i].exp_bcd, vecs[i].exp_st, (vecs[i].exp_st == 2'd0), vecs[i].exp_dp});
        end

        // ---------------- randomized run against the reference model ----------------
        m_n = 0; m_st = S_EMPTY; m_dp = 1'b0;
        clearn = 1'b0; key_valid = 1'b0; key_digit = 4'd0; count_en = 1'b0; tick = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step();
            #1;
            if (c % 100 == 0)
                $display("rand%0d -> %h%h:%h%h st=%0d pulse=%0b", c,
                         min_tens, min_ones, sec_tens, sec_ones, state, done_pulse);
            check($sformatf("rand%0d", c), dut_vec(),
                  {to_bcd(m_n), 2'(m_st), (m_st == S_EMPTY), m_dp});
            clearn    = ($urandom_range(0, 59) != 0);
            key_valid = ($urandom_range(0, 2) == 0);
            key_digit = 4'($urandom_range(0, 15));
            tick      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) count_en = ~count_en;
        end

        // ---------------- 99 s entry, one tick, then reset mid-run ----------------
        apply(0, 0, 0, 0, 0);
        apply(1, 1, 9, 0, 0);
        apply(1, 1, 9, 0, 0);
        apply(1, 0, 0, 1, 0);
        apply(1, 0, 0, 1, 1);
        $display("seq99 -> %h%h:%h%h st=%0d", min_tens, min_ones, sec_tens, sec_ones, state);
        check("seq99_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0098);
        check("seq99_state", state, S_RUN);
        #3;
        resetn = 1'b0;
        #1;
        $display("seq99 reset -> %h%h:%h%h st=%0d done=%0b", min_tens, min_ones, sec_tens, sec_ones,
                 state, timer_done);
        check("async_reset_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("async_reset_state", state, S_EMPTY);
        check("async_reset_timer_done", timer_done, 1'b1);
        @(posedge clk);
        #1;
        check("held_reset_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        @(negedge clk);
        resetn = 1'b1; count_en = 1'b0; tick = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset_state", state, S_EMPTY);

        // ---------------- reset at 00:01 with a tick pending: no beep ----------------
        apply(1, 1, 1, 0, 0);
        apply(1, 0, 0, 1, 0);
        check("abort_pre_state", state, S_RUN);
        count_en = 1'b1; tick = 1'b1;
        #2;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        $display("abort -> st=%0d done=%0b pulse=%0b", state, timer_done, done_pulse);
        check("abort_no_pulse", done_pulse, 1'b0);
        check("abort_timer_done", timer_done, 1'b1);
        @(negedge clk);
        resetn = 1'b1; tick = 1'b0; count_en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_no_late_pulse", done_pulse, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
